// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the rv32i stall/flush controller: FSM state encoding and
// the per-stage enable/flush bundle driven toward the datapath.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2
  } stall_ctrl_state_t;

  typedef struct packed {
    logic pc_write;
    logic pc_redirect;
    logic redir_save;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
    logic mem_wb_flush;
  } pipe_en_t;

  // Free-running pipe: every register loads, nothing is squashed.
  localparam pipe_en_t PIPE_EN_RUN = '{
    pc_write:     1'b1,
    pc_redirect:  1'b0,
    redir_save:   1'b0,
    if_id_write:  1'b1,
    if_id_flush:  1'b0,
    id_ex_write:  1'b1,
    id_ex_flush:  1'b0,
    ex_mem_write: 1'b1,
    mem_wb_write: 1'b1,
    mem_wb_flush: 1'b0
  };

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter for performance events; sticks at all-ones instead of
// wrapping so a long run never reports a misleadingly small count.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipe: arbitrates memory waits,
// mispredict redirects and load-use hazards into per-stage enables.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_use_stall_i,
  input  logic                 imem_req_i,
  input  logic                 imem_resp_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_resp_i,
  input  logic                 br_mispredict_i,
  output logic                 pc_write_o,
  output logic                 pc_redirect_o,
  output logic                 redir_save_o,
  output logic                 if_id_write_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_write_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_write_o,
  output logic                 mem_wb_write_o,
  output logic                 mem_wb_flush_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  stall_ctrl_state_t state_q, state_d;
  logic              squash_pend_q, squash_pend_d;
  pipe_en_t          en, en_o;
  logic              flush_inc;
  logic              dmem_wait, fetch_wait, squash_ret;

  assign dmem_wait  = dmem_req_i & ~dmem_resp_i;
  assign fetch_wait = imem_req_i & ~imem_resp_i;
  // A wrong-path fetch can only be pending while we are parked in a wait state.
  assign squash_ret = squash_pend_q & imem_req_i & imem_resp_i & (state_q != RUN);

  always_comb begin
    en            = PIPE_EN_RUN;
    state_d       = RUN;
    squash_pend_d = squash_pend_q;
    flush_inc     = 1'b0;
    if (dmem_wait) begin
      en.pc_write     = 1'b0;
      en.if_id_write  = 1'b0;
      en.id_ex_write  = 1'b0;
      en.ex_mem_write = 1'b0;
      en.mem_wb_write = 1'b0;
      en.mem_wb_flush = 1'b1;
      state_d         = DWAIT;
    end else begin
      if (fetch_wait) begin
        state_d = IWAIT;
      end
      if (br_mispredict_i) begin
        flush_inc      = 1'b1;
        en.if_id_flush = 1'b1;
        en.id_ex_flush = 1'b1;
        if (fetch_wait) begin
          // PC is busy with the in-flight fetch; park the target and drop that fetch later.
          en.pc_write    = 1'b0;
          en.redir_save  = 1'b1;
          squash_pend_d  = 1'b1;
        end else begin
          en.pc_redirect = 1'b1;
          squash_pend_d  = 1'b0;
        end
      end else if (fetch_wait) begin
        en.pc_write    = 1'b0;
        en.if_id_flush = 1'b1;
      end else if (squash_ret) begin
        en.if_id_flush = 1'b1;
        en.pc_redirect = 1'b1;
        squash_pend_d  = 1'b0;
      end else if (ld_use_stall_i) begin
        en.pc_write    = 1'b0;
        en.if_id_write = 1'b0;
        en.id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      squash_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      squash_pend_q <= squash_pend_d;
    end
  end

  assign en_o = rst ? PIPE_EN_RUN : en;

  assign pc_write_o     = en_o.pc_write;
  assign pc_redirect_o  = en_o.pc_redirect;
  assign redir_save_o   = en_o.redir_save;
  assign if_id_write_o  = en_o.if_id_write;
  assign if_id_flush_o  = en_o.if_id_flush;
  assign id_ex_write_o  = en_o.id_ex_write;
  assign id_ex_flush_o  = en_o.id_ex_flush;
  assign ex_mem_write_o = en_o.ex_mem_write;
  assign mem_wb_write_o = en_o.mem_wb_write;
  assign mem_wb_flush_o = en_o.mem_wb_flush;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~en_o.pc_write),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_inc & ~rst),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a behavioural priority model predicts
// each cycle's enables and counter values; a 4-bit-counter instance shows saturation.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic lu, ireq, iresp, dreq, dresp, misp;

  logic pc_write, pc_redirect, redir_save, if_id_write, if_id_flush;
  logic id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write, mem_wb_flush;
  logic [31:0] stall_cnt, flush_cnt;

  logic pc_write4, pc_redirect4, redir_save4, if_id_write4, if_id_flush4;
  logic id_ex_write4, id_ex_flush4, ex_mem_write4, mem_wb_write4, mem_wb_flush4;
  logic [3:0] stall_cnt4, flush_cnt4;

  logic [9:0] ctrl_obs;
  assign ctrl_obs = {pc_write, pc_redirect, redir_save, if_id_write, if_id_flush,
                     id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write, mem_wb_flush};

  localparam logic [9:0] CTRL_RUN = 10'b1001010110;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ld_use_stall_i(lu), .imem_req_i(ireq), .imem_resp_i(iresp),
    .dmem_req_i(dreq), .dmem_resp_i(dresp), .br_mispredict_i(misp),
    .pc_write_o(pc_write), .pc_redirect_o(pc_redirect), .redir_save_o(redir_save),
    .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush),
    .id_ex_write_o(id_ex_write), .id_ex_flush_o(id_ex_flush),
    .ex_mem_write_o(ex_mem_write), .mem_wb_write_o(mem_wb_write),
    .mem_wb_flush_o(mem_wb_flush),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipeline_stall_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .ld_use_stall_i(lu), .imem_req_i(ireq), .imem_resp_i(iresp),
    .dmem_req_i(dreq), .dmem_resp_i(dresp), .br_mispredict_i(misp),
    .pc_write_o(pc_write4), .pc_redirect_o(pc_redirect4), .redir_save_o(redir_save4),
    .if_id_write_o(if_id_write4), .if_id_flush_o(if_id_flush4),
    .id_ex_write_o(id_ex_write4), .id_ex_flush_o(id_ex_flush4),
    .ex_mem_write_o(ex_mem_write4), .mem_wb_write_o(mem_wb_write4),
    .mem_wb_flush_o(mem_wb_flush4),
    .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
  );

  typedef struct {
    logic [9:0]  ctrl;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [3:0]  sc4;
    logic [3:0]  fc4;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  string       phase = "init";

  logic        sq_m;
  logic [31:0] stall_m, flush_m;
  logic [3:0]  stall4_m, flush4_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected enables {pc_w,pc_redir,save,ifid_w,ifid_f,idex_w,idex_f,exmem_w,memwb_w,memwb_f}
  function automatic void model(input logic l, ir, irs, dr, drs, mp, sq,
                                output logic [9:0] c, output logic finc, output logic sqn);
    c    = CTRL_RUN;
    finc = 1'b0;
    sqn  = sq;
    if (dr && !drs) begin
      c = 10'b0000000001;
    end else if (mp) begin
      finc = 1'b1;
      c[5] = 1'b1;
      c[3] = 1'b1;
      if (ir && !irs) begin
        c[9] = 1'b0;
        c[7] = 1'b1;
        sqn  = 1'b1;
      end else begin
        c[8] = 1'b1;
        sqn  = 1'b0;
      end
    end else if (ir && !irs) begin
      c[9] = 1'b0;
      c[5] = 1'b1;
    end else if (ir && irs && sq) begin
      c[5] = 1'b1;
      c[8] = 1'b1;
      sqn  = 1'b0;
    end else if (l) begin
      c[9] = 1'b0;
      c[6] = 1'b0;
      c[3] = 1'b1;
    end
  endfunction

  task automatic step(input logic l, ir, irs, dr, drs, mp);
    exp_t       e;
    logic [9:0] c;
    logic       finc, sqn;
    @(posedge clk);
    #1;
    lu = l; ireq = ir; iresp = irs; dreq = dr; dresp = drs; misp = mp;
    model(l, ir, irs, dr, drs, mp, sq_m, c, finc, sqn);
    e.ctrl = c; e.sc = stall_m; e.fc = flush_m; e.sc4 = stall4_m; e.fc4 = flush4_m;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_eq({phase, "/ctrl"},   {22'd0, ctrl_obs},   {22'd0, e.ctrl});
    check_eq({phase, "/stall"},  stall_cnt,           e.sc);
    check_eq({phase, "/flush"},  flush_cnt,           e.fc);
    check_eq({phase, "/stall4"}, {28'd0, stall_cnt4}, {28'd0, e.sc4});
    if (!c[9]) begin
      if (stall_m != 32'hFFFF_FFFF) stall_m++;
      if (stall4_m != 4'hF)         stall4_m++;
    end
    if (finc) begin
      if (flush_m != 32'hFFFF_FFFF) flush_m++;
      if (flush4_m != 4'hF)         flush4_m++;
    end
    sq_m = sqn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "/ctrl"},   {22'd0, ctrl_obs},   {22'd0, CTRL_RUN});
    check_eq({tag, "/stall"},  stall_cnt,           32'd0);
    check_eq({tag, "/flush"},  flush_cnt,           32'd0);
    check_eq({tag, "/stall4"}, {28'd0, stall_cnt4}, 32'd0);
    check_eq({tag, "/flush4"}, {28'd0, flush_cnt4}, 32'd0);
  endtask

  task automatic model_reset();
    sq_m = 1'b0; stall_m = '0; flush_m = '0; stall4_m = '0; flush4_m = '0;
  endtask

  initial begin
    rst = 1'b1;
    lu = 0; ireq = 0; iresp = 0; dreq = 0; dresp = 0; misp = 0;
    model_reset();
    #1;
    check_reset_state("reset0");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    phase = "idle";     idle(2);

    phase = "loaduse";  step(1, 0, 0, 0, 0, 0); idle(2);

    phase = "dwait5";
    repeat (4) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(1);

    phase = "misp_iwait";
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    idle(1);

    phase = "combo";
    repeat (3) step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    idle(1);

    phase = "double_misp";
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0);
    idle(1);

    phase = "dwait_to_iwait";
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 0, 0);

    phase = "resp_noreq";
    step(0, 0, 1, 0, 0, 0);

    phase = "saturate";
    repeat (20) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(2);

    phase = "random";
    for (int i = 0; i < 150; i++) begin
      logic [31:0] r;
      r = $urandom;
      step(r[0] & r[1], sq_m ? 1'b1 : r[2], r[3], r[4] & r[5], r[6], r[7] & r[8] & r[9]);
    end
    idle(2);

    phase = "rst_mid_dwait";
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_state("rst_mid_dwait");
    model_reset();
    @(posedge clk);
    #2;
    lu = 0; ireq = 0; iresp = 0; dreq = 0; dresp = 0; misp = 0;
    rst = 1'b0;
    phase = "after_rst";
    step(0, 1, 1, 0, 0, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
